// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// slave: the loader side; master: the stream source / memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, wr_en, wr_addr, wr_data);
  modport master (output byte_valid, byte_data,
                  input  byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a count byte and N little-endian words, then writes them to imem and releases cpu_reset.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int MAX_WORDS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         err
);
  localparam int KW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]  b_q, b_d;
  logic [23:0] word_q, word_d;   // first three bytes of the word in flight
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  logic        rdy;
  logic        xfer;

  assign xfer = bus.byte_valid & rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      b_q     <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      b_q     <= b_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    b_d     = b_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    rdy     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = COUNT;
      COUNT: begin
        rdy = 1'b1;
        if (xfer) begin
          n_d = bus.byte_data;
          k_d = '0;
          b_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (bus.byte_data == 8'd0 || {24'd0, bus.byte_data} > 32'(MAX_WORDS))
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        rdy = 1'b1;
        if (xfer) begin
          word_d = {bus.byte_data, word_q[23:8]};
          b_d    = b_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_data;
`endif
          if (b_q == 2'd3) begin
            addr_d  = 32'(k_q) << 2;
            data_d  = {bus.byte_data, word_q};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (32'(k_q) + 32'd1 < {24'd0, n_q}) begin
          k_d     = k_q + 1'b1;
          state_d = DATA;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rdy = 1'b1;
        if (xfer) state_d = (bus.byte_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE:    if (start) state_d = COUNT;
      ERROR:   if (start) state_d = COUNT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_ready = rdy;
  assign bus.wr_en      = (state_q == WRITE);
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERROR);
  assign cpu_reset      = (state_q != DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: queue model of expected imem writes checked every cycle, plus status checks.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, err;

  imem_loader_if bus();

  imem_loader #(.MAX_WORDS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          due = 1'b0;
  logic [31:0] last_a = '0;
  logic [31:0] last_d = '0;
  logic [31:0] words [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: a strobe exactly when a word completed on the previous edge, holding otherwise.
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    forever begin
      @(negedge clk);
      if (due) begin
        chk("wr_en_strobe", {31'd0, bus.wr_en}, 32'd1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.a);
          chk("wr_data", bus.wr_data, e.d);
          last_a = e.a;
          last_d = e.d;
        end else begin
          n_chk++; n_err++;
          $display("FAIL write_queue: got empty expected pending entry at %0t", $time);
        end
        due = 1'b0;
      end else begin
        chk("wr_en_idle", {31'd0, bus.wr_en}, 32'd0);
        chk("wr_addr_hold", bus.wr_addr, last_a);
        chk("wr_data_hold", bus.wr_data, last_d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
    @(posedge clk);
    exp_q.delete(); due = 1'b0; last_a = '0; last_d = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    int t;
    repeat (idle) begin @(negedge clk); bus.byte_valid = 1'b0; end
    @(negedge clk);
    bus.byte_valid = 1'b1; bus.byte_data = b;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      n_chk++; n_err++;
      $display("FAIL byte_ready_wait: got timeout expected ready for byte %h", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic status(input string nm, input bit d, input bit e, input bit cr, input bit rd);
    chk({nm, "_done"}, {31'd0, done}, {31'd0, d});
    chk({nm, "_err"}, {31'd0, err}, {31'd0, e});
    chk({nm, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    chk({nm, "_byte_ready"}, {31'd0, bus.byte_ready}, {31'd0, rd});
  endtask

  // Count byte then n words from words[]; assumes the loader is already in COUNT.
  task automatic load(input int n, input bit idles, input bit hold, input bit good);
    logic [7:0] cs, b;
    cs = '0;
    send_byte(8'(n), 0);
    if (hold && n > 1) start = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) start = 1'b0;
      exp_q.push_back('{a: 32'(4 * k), d: words[k]});
      for (int j = 0; j < 4; j++) begin
        b  = words[k][8*j +: 8];
        cs = cs ^ b;
        send_byte(b, idles ? (k * 4 + j) % 4 : 0);
      end
      due = 1'b1;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(good ? cs : (cs ^ 8'h01), 0);
`else
    if (!good) $display("note: checksum disabled, good flag unused");
`endif
  endtask

  task automatic fin(input string nm, input bit ok);
    settle();
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
`endif
    status(nm, ok, !ok, !ok, 1'b0);
    chk({nm, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      words[i] = 32'h0000_0013 ^ (32'(i) << 20) ^ (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;

    // reset values
    do_reset();
    status("reset", 1'b0, 1'b0, 1'b1, 1'b0);

    // single literal word
    pulse_start();
    status("count_state", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back('{a: 32'h0, d: 32'h0198_06B3});
    send_byte(8'h01, 0);
    send_byte(8'hB3, 0);
    send_byte(8'h06, 0);
    send_byte(8'h98, 0);
    send_byte(8'h01, 0);
    due = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hB3 ^ 8'h06 ^ 8'h98 ^ 8'h01, 0);
`endif
    fin("one_word", 1'b1);

    // restart from DONE; N=3 with idle gaps and start held during DATA
    pulse_start();
    status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    load(3, 1'b1, 1'b1, 1'b1);
    fin("three_words", 1'b1);

    // bad counts
    pulse_start();
    send_byte(8'h00, 0);
    settle();
    status("count_zero", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    status("err_clear", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h11, 0);
    settle();
    status("count_17", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    status("err_clear2", 1'b0, 1'b0, 1'b1, 1'b1);

    // full capacity, last address 60
    load(16, 1'b0, 1'b0, 1'b1);
    fin("max_words", 1'b1);

    // reset mid-word, then a fresh load
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    status("mid_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start();
    load(2, 1'b1, 1'b0, 1'b1);
    fin("after_reset", 1'b1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    words[0] = 32'h0094_8663;
    load(1, 1'b0, 1'b0, 1'b0);
    fin("bad_checksum", 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
